phoenix_dl_ctrl: RTL and testbench



---
 rtl/phoenix_dl_ctrl.sv | 135 +++++++++++++
 tb/tb_phoenix_dl_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phoenix_dl_ctrl.sv
// ROM download controller: forwards HPS image bytes to the core, validates the image
// size and range, and sequences the core reset around loads and user reset requests.
module phoenix_dl_ctrl #(
    parameter int unsigned ROM_BYTES   = 16384,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] byte_count
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    localparam logic [25:0] L_ROM_LIMIT = 26'(ROM_BYTES);
    localparam logic [16:0] L_ROM_COUNT = 17'(ROM_BYTES);
    localparam logic [7:0]  L_HOLD      = 8'(HOLD_CYCLES);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [15:0] r_dn_addr;
    logic [7:0]  r_dn_data;
    logic        r_dn_wr;
    logic        r_load_done;
    logic        r_load_error;
    logic [15:0] r_byte_count;
    logic        r_overflow;
    logic [7:0]  r_hold_cnt;

    logic w_accept;
    logic w_in_range;
    logic w_image_ok;
    logic w_enter_load;
    logic w_hold_load;

    assign w_accept     = (r_state == ST_LOAD) && ioctl_wr;
    assign w_in_range   = {1'b0, ioctl_addr} < L_ROM_LIMIT;
    assign w_image_ok   = !r_overflow && ({1'b0, r_byte_count} == L_ROM_COUNT);
    assign w_enter_load = (w_state_next == ST_LOAD) && (r_state != ST_LOAD);
    // Counter reloads on HOLD entry and for every cycle user_reset is held in HOLD.
    assign w_hold_load  = (w_state_next == ST_HOLD) && ((r_state != ST_HOLD) || user_reset);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (ioctl_download) w_state_next = ST_LOAD;
            ST_LOAD:  if (!ioctl_download) w_state_next = ST_CHECK;
            ST_CHECK: w_state_next = w_image_ok ? ST_HOLD : ST_ERROR;
            ST_HOLD: begin
                if (ioctl_download)        w_state_next = ST_LOAD;
                else if (user_reset)       w_state_next = ST_HOLD;
                else if (r_hold_cnt <= 8'd1) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (ioctl_download)  w_state_next = ST_LOAD;
                else if (user_reset) w_state_next = ST_HOLD;
            end
            ST_ERROR: if (ioctl_download) w_state_next = ST_LOAD;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (w_hold_load) begin
                r_hold_cnt <= L_HOLD;
            end else if ((r_state == ST_HOLD) && (r_hold_cnt != 8'd0)) begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dn_wr      <= 1'b0;
            r_dn_addr    <= 16'd0;
            r_dn_data    <= 8'd0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_byte_count <= 16'd0;
            r_overflow   <= 1'b0;
        end else begin
            r_dn_wr <= w_accept && w_in_range;
            if (w_accept && w_in_range) begin
                r_dn_addr <= ioctl_addr[15:0];
                r_dn_data <= ioctl_dout;
            end
            if (w_enter_load) begin
                r_byte_count <= 16'd0;
                r_overflow   <= 1'b0;
                r_load_done  <= 1'b0;
                r_load_error <= 1'b0;
            end else begin
                if (w_accept) begin
                    // Out-of-range writes still count toward the image size.
                    if (r_byte_count == 16'hFFFF) r_overflow <= 1'b1;
                    else                          r_byte_count <= r_byte_count + 16'd1;
                    if (!w_in_range) r_overflow <= 1'b1;
                end
                if (r_state == ST_CHECK) begin
                    if (w_image_ok) r_load_done  <= 1'b1;
                    else            r_load_error <= 1'b1;
                end
            end
        end
    end

    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign dn_wr      = r_dn_wr;
    assign core_reset = (r_state != ST_RUN) || user_reset;
    assign load_done  = r_load_done;
    assign load_error = r_load_error;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_phoenix_dl_ctrl.sv
// Randomized scoreboard bench for phoenix_dl_ctrl with a small image (16 bytes, hold 4).
module tb_phoenix_dl_ctrl;

    localparam int ROM  = 16;
    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        user_reset;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        core_reset;
    logic        load_done;
    logic        load_error;
    logic [15:0] byte_count;

    int checks   = 0;
    int failures = 0;
    logic [23:0] exp_q[$];

    phoenix_dl_ctrl #(.ROM_BYTES(ROM), .HOLD_CYCLES(HOLD)) dut (
        .clk           (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .user_reset    (user_reset),
        .dn_addr       (dn_addr),
        .dn_data       (dn_data),
        .dn_wr         (dn_wr),
        .core_reset    (core_reset),
        .load_done     (load_done),
        .load_error    (load_error),
        .byte_count    (byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every ROM write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && dn_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dn_wr actual=%0h required=none", {dn_addr, dn_data});
            end else begin
                check("dn_write", {8'd0, dn_addr, dn_data}, {8'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles after the current (already sampled) cycle until core_reset is released.
    task automatic cycles_to_run(output int n);
        n = 0;
        while (core_reset === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic start_load();
        tick();
        ioctl_download = 1'b1;
        tick();
        @(negedge clk);
        check("entry_core_reset", core_reset, 1);
        check("entry_byte_count", byte_count, 0);
        check("entry_load_done", load_done, 0);
        check("entry_load_error", load_error, 0);
    endtask

    task automatic write_byte(input logic [24:0] a, output bit oor);
        logic [7:0] d;
        repeat ($urandom_range(0, 2)) begin
            tick();
            ioctl_wr = 1'b0;
        end
        tick();
        d = 8'($urandom);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        oor = (a >= 25'(ROM));
        if (!oor) exp_q.push_back({a[15:0], d});
    endtask

    task automatic download(input int n, input int bad_pos, output bit ok);
        bit ovf;
        bit oor;
        int hold_len;
        logic [24:0] a;
        start_load();
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = (i == bad_pos) ? 25'(ROM + $urandom_range(0, 1000)) : 25'(i);
            write_byte(a, oor);
            ovf |= oor;
        end
        // Sometimes drop the download in the same cycle as the last strobe.
        if ($urandom_range(0, 1) == 1) begin
            ioctl_download = 1'b0;
        end else begin
            tick();
            ioctl_wr       = 1'b0;
            ioctl_download = 1'b0;
        end
        tick();
        ioctl_wr = 1'b0;
        tick();
        @(negedge clk);
        ok = !ovf && (n == ROM);
        check("result_load_done", load_done, ok);
        check("result_load_error", load_error, !ok);
        check("result_byte_count", byte_count, n);
        check("result_core_reset", core_reset, 1);
        check("writes_drained", exp_q.size(), 0);
        if (ok) begin
            cycles_to_run(hold_len);
            check("hold_release", hold_len, HOLD);
        end
    endtask

    task automatic soak(input int ncyc);
        int bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            user_reset = 1'($urandom_range(0, 1));
            ioctl_wr   = ($urandom_range(0, 3) == 0);
            ioctl_addr = 25'($urandom_range(0, 15));
            @(negedge clk);
            if (core_reset !== 1'b1) bad++;
        end
        tick();
        user_reset = 1'b0;
        ioctl_wr   = 1'b0;
        check("error_core_reset_held", bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        bit oor;
        int n;
        int bad_pos;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        user_reset     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_core_reset", core_reset, 1);
        check("rst_dn_wr", dn_wr, 0);
        check("rst_dn_addr", dn_addr, 0);
        check("rst_load_done", load_done, 0);
        check("rst_byte_count", byte_count, 0);
        tick();
        reset = 1'b0;

        download(ROM, -1, ok);

        // user_reset pulse of 3 cycles in RUN
        tick();
        user_reset = 1'b1;
        @(negedge clk);
        check("user_reset_comb", core_reset, 1);
        tick();
        tick();
        tick();
        user_reset = 1'b0;
        @(negedge clk);
        cycles_to_run(n);
        check("user_reset_release", n, HOLD);
        check("user_reset_keeps_done", load_done, 1);

        download(ROM, -1, ok);
        download(ROM - 1, -1, ok);
        soak(1000);
        download(ROM, int'($urandom_range(0, ROM - 1)), ok);
        soak(40);

        for (int k = 0; k < 6; k++) begin
            n       = int'($urandom_range(ROM - 2, ROM + 1));
            bad_pos = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            download(n, bad_pos, ok);
            if (!ok) soak(20);
        end

        // Async reset in the middle of a load
        start_load();
        for (int i = 0; i < 8; i++) write_byte(25'(i), oor);
        tick();
        ioctl_wr = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_dn_wr", dn_wr, 0);
        check("abort_dn_addr", dn_addr, 0);
        check("abort_dn_data", dn_data, 0);
        check("abort_byte_count", byte_count, 0);
        check("abort_load_done", load_done, 0);
        check("abort_load_error", load_error, 0);
        check("abort_core_reset", core_reset, 1);
        tick();
        tick();
        reset = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("post_abort_byte_count", byte_count, 0);
        check("post_abort_core_reset", core_reset, 1);
        tick();
        ioctl_download = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("post_abort_error", load_error, 1);
        download(ROM, -1, ok);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
